// File: rtl/zeroenc_seq.sv
// Multi-cycle first-matching-bit encoder: scans the operand chunkwidth bits per cycle,
// LSB-first or MSB-first, matching ones or zeros, and stops at the first chunk with a hit.
module zeroenc_seq #(
  parameter int iwidth     = 105,
  parameter int shiftwidth = 7,
  parameter int chunkwidth = 16
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_ena,
  output logic                  o_ready,
  input  logic [iwidth-1:0]     i_value,
  input  logic                  i_msb_first,
  input  logic                  i_invert,
  output logic                  o_valid,
  output logic [shiftwidth-1:0] o_shift,
  output logic                  o_zero
);

  localparam int NCHUNK = (iwidth + chunkwidth - 1) / chunkwidth;
  localparam int PW     = NCHUNK * chunkwidth;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LW     = (chunkwidth > 1) ? $clog2(chunkwidth) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         data_q;
  logic                  msb_q;
  logic [CW-1:0]         cnt_q;
  logic [shiftwidth-1:0] shift_q;
  logic                  zero_q;

  logic [chunkwidth-1:0] chunk;
  logic [LW-1:0]         local_idx;
  logic                  hit;
  logic                  last;
  logic [shiftwidth-1:0] result;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Chunk mux selected by the scan counter.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    chunk = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      if (cnt_q == CW'(c)) chunk = data_q[c*chunkwidth +: chunkwidth];
    end
  end

  // Local priority encoder; the last assignment in loop order wins.
  always_comb begin
    local_idx = '0;
    hit       = |chunk;
    if (msb_q) begin
      for (int i = 0; i < chunkwidth; i++) begin
        if (chunk[i]) local_idx = LW'(i);
      end
    end else begin
      for (int i = chunkwidth - 1; i >= 0; i--) begin
        if (chunk[i]) local_idx = LW'(i);
      end
    end
  end

  assign last   = msb_q ? (cnt_q == '0) : (cnt_q == CW'(NCHUNK - 1));
  assign result = shiftwidth'(int'(cnt_q) * chunkwidth + int'(local_idx));

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_ena) state_d = SCAN;
      SCAN:    if (hit || last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; result registers hold between strobes.
  always_comb begin
    o_ready = (state_q == IDLE);
    o_valid = (state_q == DONE);
  end

  assign o_shift = shift_q;
  assign o_zero  = zero_q;

  // Datapath: operand capture, scan counter and result registers.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      data_q  <= '0;
      msb_q   <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_ena) begin
            // Zero-extension after inversion keeps the pad bits from ever matching.
            data_q <= PW'(i_value ^ {iwidth{i_invert}});
            msb_q  <= i_msb_first;
            cnt_q  <= i_msb_first ? CW'(NCHUNK - 1) : '0;
          end
        end
        SCAN: begin
          if (hit) begin
            shift_q <= result;
            zero_q  <= 1'b0;
          end else if (last) begin
            shift_q <= '0;
            zero_q  <= 1'b1;
          end else begin
            cnt_q <= msb_q ? (cnt_q - CW'(1)) : (cnt_q + CW'(1));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zeroenc_seq.sv
// Directed and randomised checks of zeroenc_seq (iwidth=105, chunkwidth=16, 7 chunks).
module tb_zeroenc_seq;

  localparam int IW = 105;
  localparam int SW = 7;

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic          ready;
  logic [IW-1:0] value;
  logic          msb_first;
  logic          invert;
  logic          valid;
  logic [SW-1:0] shift;
  logic          zero;

  int vectors     = 0;
  int miscompares = 0;

  zeroenc_seq #(.iwidth(IW), .shiftwidth(SW), .chunkwidth(16)) dut (
    .i_clk(clk), .i_nrst(rst_n), .i_ena(ena), .o_ready(ready),
    .i_value(value), .i_msb_first(msb_first), .i_invert(invert),
    .o_valid(valid), .o_shift(shift), .o_zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] rand_word();
    return IW'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  // Reference encoder: {zero, shift}, straight bit scan independent of chunking.
  function automatic logic [SW:0] ref_enc(input logic [IW-1:0] v, input logic m, input logic inv);
    logic [IW-1:0] x;
    x = v ^ {IW{inv}};
    if (m) begin
      for (int i = IW - 1; i >= 0; i--) if (x[i]) return {1'b0, SW'(i)};
    end else begin
      for (int i = 0; i < IW; i++) if (x[i]) return {1'b0, SW'(i)};
    end
    return {1'b1, {SW{1'b0}}};
  endfunction

  // One request from an idle cycle T; optional junk i_ena pulse at cycle T+pulse.
  task automatic request(input string tag, input logic [IW-1:0] v, input logic m, input logic inv,
                         input int exp_shift, input logic exp_zero, input int exp_lat,
                         input int pulse);
    int   n;
    logic ready_low;
    check({tag, ".ready_before"}, 128'(ready), 128'(1));
    value = v; msb_first = m; invert = inv; ena = 1'b1;
    tick();
    ena = 1'b0;
    n = 1;
    ready_low = 1'b1;
    while (!valid && n < 40) begin
      if (ready) ready_low = 1'b0;
      if (n == pulse) ena = 1'b1;
      else            ena = 1'b0;
      value = rand_word(); msb_first = ~msb_first; invert = ~invert;
      tick();
      n++;
    end
    ena = 1'b0;
    check({tag, ".latency"},   128'(n),        128'(exp_lat));
    check({tag, ".shift"},     128'(shift),    128'(exp_shift));
    check({tag, ".zero"},      128'(zero),     128'(exp_zero));
    check({tag, ".ready_low"}, 128'(ready_low && !ready), 128'(1));
    tick();
    check({tag, ".valid_1cyc"}, 128'(valid), 128'(0));
    check({tag, ".hold"},       128'({zero, shift}), 128'({exp_zero, SW'(exp_shift)}));
  endtask

  initial begin
    logic [IW-1:0] v;
    logic [SW:0]   exp_q[$];
    logic [SW:0]   e;
    logic          m, inv, seen;
    int            results;

    rst_n = 1'b0; ena = 1'b0; value = '0; msb_first = 1'b0; invert = 1'b0;
    #12;
    check("reset.ready", 128'(ready), 128'(1));
    check("reset.outs",  128'({valid, zero, shift}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed cases; latency counts cycles from accept cycle T to the o_valid cycle.
    request("lsb_bit40",  IW'(1) << 40, 1'b0, 1'b0, 40, 1'b0, 4, 0);
    request("lsb_zero",   '0,           1'b0, 1'b0, 0,  1'b1, 8, 0);
    request("msb_3_100",  (IW'(1) << 3) | (IW'(1) << 100), 1'b1, 1'b0, 100, 1'b0, 2, 0);
    request("msb_3",      IW'(1) << 3,  1'b1, 1'b0, 3,  1'b0, 8, 0);
    request("inv_bit17",  ~(IW'(1) << 17), 1'b0, 1'b1, 17, 1'b0, 3, 0);
    request("inv_ones",   '1,           1'b0, 1'b1, 0,  1'b1, 8, 0);
    request("lsb_bit104", IW'(1) << 104, 1'b0, 1'b0, 104, 1'b0, 8, 0);
    request("msb_bit0",   IW'(1),       1'b1, 1'b0, 0,  1'b0, 8, 0);
    request("msb_inv",    ~(IW'(1) << 104), 1'b1, 1'b1, 104, 1'b0, 2, 0);
    request("ignore_ena", IW'(1) << 90, 1'b0, 1'b0, 90, 1'b0, 7, 2);

    // Reset while scanning a zero operand: pending result must be dropped.
    value = '0; msb_first = 1'b0; invert = 1'b0; ena = 1'b1;
    tick();
    ena = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #2;
    check("rst_mid.ready", 128'(ready), 128'(1));
    check("rst_mid.outs",  128'({valid, zero, shift}), 128'(0));
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (valid) seen = 1'b1;
      tick();
    end
    check("rst_mid.no_valid", 128'(seen), 128'(0));
    request("after_rst", IW'(1) << 7, 1'b1, 1'b0, 7, 1'b0, 8, 0);

    // Streaming with i_ena held high; operands keep changing while busy.
    results = 0;
    ena = 1'b1;
    for (int cyc = 0; cyc < 30000 && results < 2000; cyc++) begin
      if (valid) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = '1;
        check("stream.result", 128'({zero, shift}), 128'(e));
        results++;
      end
      case ($urandom_range(0, 3))
        0:       v = rand_word();
        1:       v = IW'(1) << $urandom_range(0, IW - 1);
        2:       v = $urandom_range(0, 1) ? '0 : '1;
        default: v = rand_word() & rand_word() & rand_word() & rand_word() & rand_word();
      endcase
      m   = 1'($urandom_range(0, 1));
      inv = 1'($urandom_range(0, 1));
      value = v; msb_first = m; invert = inv;
      if (ready) exp_q.push_back(ref_enc(v, m, inv));
      tick();
    end
    ena = 1'b0;
    check("stream.count", 128'(results), 128'(2000));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
